// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data RAM arbiter.
// Optional build macro used by the arbiter: DATA_RAM_BYTE_WRITE_EN.
package data_ram_pkg;

    localparam int RD_LAT_MAX = 3;
    localparam int NCH_MAX    = 4;
    localparam int PTR_W      = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // First requester at or after ptr, wrapping. Channels above NCH are
    // tied off to zero by the caller, so wrapping over NCH_MAX gives the
    // same answer as wrapping over NCH.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NCH_MAX-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NCH_MAX - 1; k >= 0; k--) begin
            idx = ptr + PTR_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/data_ram_arb_if.sv
// Requester-side bus of the data RAM arbiter: per-channel request lanes
// packed by channel, plus the shared read return.
interface data_ram_arb_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    logic [NCH-1:0]                req;
    logic [NCH-1:0]                we;
    logic [NCH-1:0][AW-1:0]        addr;
    logic [NCH-1:0][DW-1:0]        wdata;
    logic [NCH-1:0][DW/8-1:0]      be;
    logic [NCH-1:0]                gnt;
    logic [NCH-1:0]                rvalid;
    logic [DW-1:0]                 rdata;
    logic                          busy;

    modport master (output req, we, addr, wdata, be,
                    input  gnt, rvalid, rdata, busy);
    modport slave  (input  req, we, addr, wdata, be,
                    output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/data_ram_sram.sv
// Single-port synchronous RAM with per-byte write mask and an RD_LAT-deep
// read pipeline. Swap this module for the vendor macro.
module data_ram_sram #(
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 14,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DW-1:0]         wdata,
    input  logic [DW/8-1:0]       wmask,
    output logic [DW-1:0]         rdata,
    output logic                  rvld
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DW-1:0]             mem [DEPTH];
    logic [RD_LAT:1][DW-1:0]   dpipe;
    logic [RD_LAT:0]           vld_pipe;

    assign vld_pipe[0] = en && !we;

    // Byte-masked write port.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Array read followed by RD_LAT-1 output register stages.
    always_ff @(posedge clk) begin
        if (vld_pipe[0]) dpipe[1] <= mem[idx];
        for (int k = 2; k <= RD_LAT; k++) dpipe[k] <= dpipe[k-1];
    end

    // Read-valid shift register tracking data through the pipeline.
    always_ff @(posedge clk) begin
        if (!rstn) vld_pipe[RD_LAT:1] <= '0;
        else       vld_pipe[RD_LAT:1] <= vld_pipe[RD_LAT-1:0];
    end

    assign rdata = dpipe[RD_LAT];
    assign rvld  = vld_pipe[RD_LAT];

endmodule

// File: rtl/data_ram_arb.sv
// Round-robin front end letting NCH requesters share one data RAM.
// Macro DATA_RAM_BYTE_WRITE_EN: when defined, writes honour be per byte
// lane; when undefined, be is ignored and every write is a full word.
module data_ram_arb
    import data_ram_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int DEPTH_LOG2 = 14,
    parameter int RD_LAT     = 2,
    parameter int NCH        = 2
) (
    input  logic           clk,
    input  logic           rstn,
    data_ram_arb_if.slave  bus
);
    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr, owner_q, pick;
    logic [1:0]           lat_cnt;
    logic [NCH_MAX-1:0]   req_pad;
    logic                 accept;
    logic                 sel_we;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic [DW/8-1:0]      sel_be;
    logic [DW/8-1:0]      wmask;
    logic [DW-1:0]        ram_q, rdata_q;
    logic                 ram_vld;
    logic [NCH-1:0]       gnt_c, rvalid_c;
    logic                 unused_addr;

    // Widen requests to NCH_MAX and pick the round-robin winner.
    always_comb begin
        req_pad = '0;
        for (int i = 0; i < NCH; i++) req_pad[i] = bus.req[i];
        pick = rr_pick(req_pad, rr_ptr);
    end

    // Route the winning channel's command to the RAM port.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pick == PTR_W'(i)) begin
                sel_we    = bus.we[i];
                sel_addr  = bus.addr[i];
                sel_wdata = bus.wdata[i];
                sel_be    = bus.be[i];
            end
        end
    end

`ifdef DATA_RAM_BYTE_WRITE_EN
    assign wmask = sel_be;
`else
    logic unused_be;
    assign wmask     = '1;
    assign unused_be = ^sel_be;
`endif

    // Only the word-index bits select a RAM row; the rest alias.
    assign unused_addr = ^sel_addr;

    // Next-state, grant and read-return decode.
    always_comb begin
        state_d  = state_q;
        gnt_c    = '0;
        rvalid_c = '0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rstn && (|bus.req)) begin
                    accept = 1'b1;
                    for (int i = 0; i < NCH; i++) gnt_c[i] = (pick == PTR_W'(i));
                    if (!sel_we) state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    for (int i = 0; i < NCH; i++)
                        rvalid_c[i] = ram_vld && (owner_q == PTR_W'(i));
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State, pointer, owner, latency counter and read-data hold registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            owner_q <= '0;
            lat_cnt <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rr_ptr <= (pick == PTR_W'(NCH - 1)) ? '0 : pick + 2'd1;
                if (!sel_we) begin
                    owner_q <= pick;
                    lat_cnt <= 2'(RD_LAT - 1);
                end
            end else if (state_q == RD_WAIT && lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            if (|rvalid_c) rdata_q <= ram_q;
        end
    end

    assign bus.gnt    = gnt_c;
    assign bus.rvalid = rstn ? rvalid_c : '0;
    assign bus.busy   = rstn && (state_q == RD_WAIT);
    assign bus.rdata  = !rstn ? '0 : ((|rvalid_c) ? ram_q : rdata_q);

    data_ram_sram #(
        .DW         (DW),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RD_LAT     (RD_LAT)
    ) u_sram (
        .clk   (clk),
        .rstn  (rstn),
        .en    (accept),
        .we    (sel_we),
        .idx   (sel_addr[DEPTH_LOG2+1:2]),
        .wdata (sel_wdata),
        .wmask (wmask),
        .rdata (ram_q),
        .rvld  (ram_vld)
    );

endmodule
